mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width.
REQ-002 SHALL have parameter MEM_LAT, default 2, cycles from issue to read data (legal range >=1).
REQ-003 SHALL have parameter STARVE_MAX, default 4, fetch starvation limit in cycles (legal range >=1).
REQ-004 SHALL have clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have if_req_i  input  1  fetch read request.
REQ-007 SHALL have if_addr_i  input  DATA_W  fetch address.
REQ-008 SHALL have if_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 SHALL have if_rvalid_o  output  1  fetch read data valid.
REQ-010 SHALL have if_rdata_o  output  DATA_W  fetch read data.
REQ-011 SHALL have dm_req_i  input  1  data-memory request.
REQ-012 SHALL have dm_we_i  input  1  data request is a write.
REQ-013 SHALL have dm_addr_i  input  DATA_W  data address.
REQ-014 SHALL have dm_wdata_i  input  DATA_W  write data.
REQ-015 SHALL have dm_gnt_o  output  1  data request accepted this cycle.
REQ-016 SHALL have dm_rvalid_o  output  1  data completion (read data valid or write done).
REQ-017 SHALL have dm_rdata_o  output  DATA_W  data read data.
REQ-018 SHALL have mem_en_o, mem_we_o  output  1 each  memory command strobe and write enable.
REQ-019 SHALL have mem_addr_o, mem_wdata_o  output  DATA_W each  memory address and write data.
REQ-020 SHALL have mem_rdata_i  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en_o.

Function
REQ-021 SHALL arbitrate one shared single-port memory between fetch and data requesters, one outstanding access at a time.
REQ-022 SHALL implement FSM IDLE/BUSY. IDLE plus any request goes to BUSY. BUSY returns to IDLE, or re-issues, when the latency counter expires.
REQ-023 SHALL grant combinationally in IDLE, or in the BUSY cycle where completion occurs (back-to-back issue): gnt is a 1-cycle pulse, and mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o are driven from the winner in that same cycle.
REQ-024 SHALL give data priority over fetch, except when the starvation count equals STARVE_MAX, in which case fetch wins.
REQ-025 SHALL drive mem_we_o=1 only for a granted data write; fetch is always read.
REQ-026 SHALL record owner and latency counter at grant, and pulse the owner's rvalid exactly MEM_LAT cycles after its gnt; rdata = mem_rdata_i in that cycle, else 0.
REQ-027 SHALL, for a data write, pulse dm_rvalid_o at grant+MEM_LAT with dm_rdata_o=0.
REQ-028 SHALL not grant in any cycle between issue and completion; requesters hold req/addr/wdata until gnt.
REQ-029 SHALL accept withdrawal of a request before grant with no side effect.
REQ-030 SHALL increment the starvation counter when if_req_i=1 and if_gnt_o=0, saturating at STARVE_MAX, and clear it on fetch grant or when if_req_i=0.
REQ-031 SHALL drive all mem_* outputs to 0 when no grant occurs.

Reset
REQ-032 SHALL, on reset_i=1 at a clock edge, enter IDLE and clear the owner, latency counter and starvation counter; this takes priority over all other events.
REQ-033 SHALL, on reset mid-access, discard the access (no rvalid); all outputs SHALL be 0 while reset_i=1.

Configuration
REQ-034 SHALL, with ARB_STARVE_GUARD_EN defined, implement the starvation counter and override per REQ-024/REQ-030.
REQ-035 SHALL, without ARB_STARVE_GUARD_EN, use strict data priority (fetch may starve) and omit the counter logic.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-036 SHALL cover: idle, if_req_i=1, if_addr_i=0x00400000 -> if_gnt_o and mem_en_o=1 with mem_addr_o=0x00400000 same cycle; if_rvalid_o=1 and if_rdata_o=0x00500113 two cycles later.
REQ-037 SHALL cover: if_req_i and dm_req_i (read 0x10010004) asserted together -> dm_gnt_o cycle 0, if_gnt_o cycle 2, dm_rvalid_o cycle 2, if_rvalid_o cycle 4.
REQ-038 SHALL cover: dm write 0x10010000/0xDEADBEEF -> mem_we_o=1 for one cycle with mem_wdata_o=0xDEADBEEF; dm_rvalid_o at +2 with dm_rdata_o=0.
REQ-039 SHALL cover: dm_req_i held high continuously with if_req_i=1 -> with macro, if_gnt_o once the count reaches 4, on the cycle-4 completion; without macro, if_gnt_o never asserts.
REQ-040 SHALL cover: reset_i pulsed one cycle after dm_gnt_o -> no dm_rvalid_o, all outputs 0, and a fresh if_req_i is granted in the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesters (fetch, data) and a shared single-port memory.
// Ports: fetch req/addr -> gnt/rvalid/rdata; data req/we/addr/wdata -> gnt/rvalid/rdata;
//        memory en/we/addr/wdata out, rdata in.
// Modports: slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              if_req_i;
    logic [DATA_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [DATA_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between a fetch and a data requester,
// one outstanding access at a time. Grants and memory commands are combinational
// (issued in IDLE or in the BUSY cycle whose access completes); completion
// (rvalid/rdata) fires exactly MEM_LAT cycles after the grant.
// Ports: clk_i, reset_i (sync, active-high), bus (mem_port_arbiter_if.slave).
// Option: define ARB_STARVE_GUARD_EN to let fetch win once it has waited
//         STARVE_MAX cycles; otherwise data always has priority.
module mem_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    mem_port_arbiter_if.slave bus
);

    // Elaboration-time legality checks on parameters
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must be >= 1");
    end

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state, state_next;
    logic               owner_dm_q;   // 1 = data owns the access in flight
    logic               owner_wr_q;   // access in flight is a data write
    logic [CNT_W-1:0]   cnt_q;        // cycles left until completion
    logic               done_c;
    logic               can_issue_c;
    logic               fetch_wins_c;
    logic               grant_if_c;
    logic               grant_dm_c;

    assign done_c      = (state == BUSY) && (cnt_q == '0);
    assign can_issue_c = !reset_i && ((state == IDLE) || done_c);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;
    logic          starve_hit_c;

    assign starve_hit_c = (starve_q == SW'(STARVE_MAX));
    assign fetch_wins_c = bus.if_req_i && (!bus.dm_req_i || starve_hit_c);

    // Counts cycles fetch waits with its request up; saturates at STARVE_MAX
    always_ff @(posedge clk_i) begin
        if (reset_i || !bus.if_req_i || grant_if_c) begin
            starve_q <= '0;
        end else if (starve_q < SW'(STARVE_MAX)) begin
            starve_q <= starve_q + SW'(1);
        end
    end
`else
    assign fetch_wins_c = bus.if_req_i && !bus.dm_req_i;
`endif

    assign grant_if_c = can_issue_c && fetch_wins_c;
    assign grant_dm_c = can_issue_c && bus.dm_req_i && !fetch_wins_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a grant in the completion cycle keeps us BUSY
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_if_c || grant_dm_c) state_next = BUSY;
            BUSY: if (done_c) state_next = (grant_if_c || grant_dm_c) ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Owner and latency tracking for the access in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_dm_q <= 1'b0;
            owner_wr_q <= 1'b0;
            cnt_q      <= '0;
        end else if (grant_if_c || grant_dm_c) begin
            owner_dm_q <= grant_dm_c;
            owner_wr_q <= grant_dm_c && bus.dm_we_i;
            cnt_q      <= CNT_W'(MEM_LAT - 1);
        end else if ((state == BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Output logic: grant/command from the winner, completion to the owner
    always_comb begin
        bus.if_gnt_o    = 1'b0;
        bus.if_rvalid_o = 1'b0;
        bus.if_rdata_o  = '0;
        bus.dm_gnt_o    = 1'b0;
        bus.dm_rvalid_o = 1'b0;
        bus.dm_rdata_o  = '0;
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;

        if (grant_dm_c) begin
            bus.dm_gnt_o    = 1'b1;
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = bus.dm_we_i;
            bus.mem_addr_o  = bus.dm_addr_i;
            bus.mem_wdata_o = bus.dm_wdata_i;
        end else if (grant_if_c) begin
            bus.if_gnt_o    = 1'b1;
            bus.mem_en_o    = 1'b1;
            bus.mem_addr_o  = bus.if_addr_i;
        end

        // Reset discards the access in flight, so no completion while it is high
        if (done_c && !reset_i) begin
            if (owner_dm_q) begin
                bus.dm_rvalid_o = 1'b1;
                bus.dm_rdata_o  = owner_wr_q ? DATA_W'(0) : bus.mem_rdata_i;
            end else begin
                bus.if_rvalid_o = 1'b1;
                bus.if_rdata_o  = bus.mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned DATA_W = 32;

    logic clk_i;
    logic reset_i;

    int checks;
    int passes;

    mem_port_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .DATA_W(DATA_W),
        .MEM_LAT(2),
        .STARVE_MAX(4)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .bus(bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory model: fixed contents, data returned two cycles after mem_en_o
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0040_0000: mem_f = 32'h0050_0113;
            32'h1001_0004: mem_f = 32'h1234_5678;
            default:       mem_f = a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    logic        p1_v, p2_v;
    logic [31:0] p1_a, p2_a;
    always @(posedge clk_i) begin
        p1_v <= bus.mem_en_o;
        p1_a <= bus.mem_addr_o;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign bus.mem_rdata_i = p2_v ? mem_f(p2_a) : 32'h0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    task automatic idle_inputs();
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = '0;
        bus.dm_wdata_i = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0040_0000;
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h1001_0004;
        step();
        @(negedge clk_i);
        checks++;
        if ({bus.if_gnt_o, bus.dm_gnt_o, bus.mem_en_o, bus.mem_we_o} !== 4'b0)
            $display("FAIL reset_strobes: got %b expected 0000",
                     {bus.if_gnt_o, bus.dm_gnt_o, bus.mem_en_o, bus.mem_we_o});
        else passes++;
        checks++;
        if ({bus.mem_addr_o, bus.if_rvalid_o, bus.dm_rvalid_o} !== '0)
            $display("FAIL reset_addr_rvalid: got %h expected 0",
                     {bus.mem_addr_o, bus.if_rvalid_o, bus.dm_rvalid_o});
        else passes++;
        step();
        idle_inputs();
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0040_0000;
        @(negedge clk_i);
        chk("fetch_gnt", 32'(bus.if_gnt_o), 32'd1);
        chk("fetch_en", 32'(bus.mem_en_o), 32'd1);
        chk("fetch_we", 32'(bus.mem_we_o), 32'd0);
        chk("fetch_addr", bus.mem_addr_o, 32'h0040_0000);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("fetch_rvalid_early", 32'(bus.if_rvalid_o), 32'd0);
        step();
        @(negedge clk_i);
        chk("fetch_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        chk("fetch_rdata", bus.if_rdata_o, 32'h0050_0113);
        step();
        @(negedge clk_i);
        chk("fetch_rvalid_after", 32'(bus.if_rvalid_o), 32'd0);
        step();
    endtask

    task automatic test_priority();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0040_0000;
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h1001_0004;
        @(negedge clk_i);
        chk("prio_c0_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        chk("prio_c0_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        chk("prio_c0_addr", bus.mem_addr_o, 32'h1001_0004);
        step();
        bus.dm_req_i = 1'b0;
        @(negedge clk_i);
        chk("prio_c1_no_gnt", 32'({bus.if_gnt_o, bus.dm_gnt_o, bus.mem_en_o}), 32'd0);
        step();
        @(negedge clk_i);
        chk("prio_c2_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        chk("prio_c2_dm_rdata", bus.dm_rdata_o, 32'h1234_5678);
        chk("prio_c2_if_gnt", 32'(bus.if_gnt_o), 32'd1);
        chk("prio_c2_addr", bus.mem_addr_o, 32'h0040_0000);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("prio_c3_quiet", 32'({bus.if_rvalid_o, bus.dm_rvalid_o, bus.mem_en_o}), 32'd0);
        step();
        @(negedge clk_i);
        chk("prio_c4_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        chk("prio_c4_if_rdata", bus.if_rdata_o, 32'h0050_0113);
        step();
    endtask

    task automatic test_write();
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h1001_0000;
        bus.dm_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("wr_gnt", 32'(bus.dm_gnt_o), 32'd1);
        chk("wr_we", 32'(bus.mem_we_o), 32'd1);
        chk("wr_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        chk("wr_addr", bus.mem_addr_o, 32'h1001_0000);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("wr_we_one_cycle", 32'({bus.mem_we_o, bus.mem_en_o}), 32'd0);
        step();
        @(negedge clk_i);
        chk("wr_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        chk("wr_rdata_zero", bus.dm_rdata_o, 32'h0);
        step();
    endtask

    task automatic test_starve();
        logic exp_if, exp_dm;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0040_0000;
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h1001_0008;
        for (int c = 0; c < 5; c++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_if = (c == 4);
            exp_dm = (c == 0) || (c == 2);
`else
            exp_if = 1'b0;
            exp_dm = (c == 0) || (c == 2) || (c == 4);
`endif
            @(negedge clk_i);
            checks++;
            if (bus.if_gnt_o !== exp_if)
                $display("FAIL starve_if_gnt c%0d: got %b expected %b", c, bus.if_gnt_o, exp_if);
            else passes++;
            checks++;
            if (bus.dm_gnt_o !== exp_dm)
                $display("FAIL starve_dm_gnt c%0d: got %b expected %b", c, bus.dm_gnt_o, exp_dm);
            else passes++;
            step();
        end
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h1001_0004;
        @(negedge clk_i);
        chk("rst_mid_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        step();
        idle_inputs();
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_outputs_zero",
            32'({bus.if_gnt_o, bus.if_rvalid_o, bus.dm_gnt_o, bus.dm_rvalid_o,
                 bus.mem_en_o, bus.mem_we_o} | 6'(|bus.mem_addr_o)), 32'd0);
        step();
        reset_i = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0040_0000;
        @(negedge clk_i);
        chk("rst_mid_if_gnt", 32'(bus.if_gnt_o), 32'd1);
        chk("rst_mid_no_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("rst_mid_c3_quiet", 32'({bus.dm_rvalid_o, bus.if_rvalid_o}), 32'd0);
        step();
        @(negedge clk_i);
        chk("rst_mid_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        chk("rst_mid_if_rdata", bus.if_rdata_o, 32'h0050_0113);
        step();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset_i = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_starve();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
